// File: rtl/ycbcr_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one RGB888->YCbCr converter between
// two pixel sources. It drives the converter start/all_end handshake, returns
// tagged results, and aborts hung conversions by timeout plus converter reset.
module ycbcr_conv_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  input  logic [23:0] s0_data,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [23:0] s1_data,
  output logic        s1_ready,
  output logic        m_valid,
  output logic [23:0] m_data,
  output logic        m_id,
  output logic        err,
  output logic        err_id,
  output logic        busy,
  output logic        conv_start,
  output logic [23:0] conv_din,
  output logic        conv_rst_n,
  input  logic        conv_end,
  input  logic [23:0] conv_dout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RELEASE,
    ST_ABORT
  } state_t;

  // Last counter value in ISSUE before the conversion is declared hung.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        r_last, w_last_next;
  logic        r_cur_id, w_cur_id_next;
  logic [1:0]  r_ready, w_ready_next;
  logic        r_conv_start, w_conv_start_next;
  logic [23:0] r_conv_din, w_conv_din_next;
  logic        r_conv_rst_n, w_conv_rst_n_next;
  logic        r_m_valid, w_m_valid_next;
  logic [23:0] r_m_data, w_m_data_next;
  logic        r_m_id, w_m_id_next;
  logic        r_err, w_err_next;
  logic        r_err_id, w_err_id_next;

  // Arbitration: a lone requester wins; on a tie the source not served last wins.
  logic        w_req;
  logic        w_gid;
  logic [23:0] w_gdata;

  assign w_req   = s0_valid | s1_valid;
  assign w_gid   = (s0_valid & s1_valid) ? ~r_last : s1_valid;
  assign w_gdata = w_gid ? s1_data : s0_data;

  // Next-state and next-output logic; pulse outputs default low every cycle.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_last_next       = r_last;
    w_cur_id_next     = r_cur_id;
    w_ready_next      = 2'b00;
    w_conv_start_next = 1'b0;
    w_conv_din_next   = r_conv_din;
    w_conv_rst_n_next = 1'b1;
    w_m_valid_next    = 1'b0;
    w_m_data_next     = r_m_data;
    w_m_id_next       = r_m_id;
    w_err_next        = 1'b0;
    w_err_id_next     = r_err_id;

    case (r_state)
      ST_IDLE, ST_RELEASE: begin
        // RELEASE drops start for one cycle so the converter returns to idle;
        // a new grant may still be taken on the edge that leaves it.
        if (w_req) begin
          w_ready_next      = w_gid ? 2'b10 : 2'b01;
          w_conv_din_next   = w_gdata;
          w_cur_id_next     = w_gid;
          w_last_next       = w_gid;
          w_conv_start_next = 1'b1;
          w_cnt_next        = 8'd0;
          w_state_next      = ST_ISSUE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        w_cnt_next = r_cnt + 8'd1;
        if (conv_end) begin
          w_m_data_next  = conv_dout;
          w_m_id_next    = r_cur_id;
          w_m_valid_next = 1'b1;
          w_state_next   = ST_RELEASE;
        end else if (r_cnt == TO_LAST) begin
          w_conv_rst_n_next = 1'b0;
          w_err_next        = 1'b1;
          w_err_id_next     = r_cur_id;
          w_cnt_next        = 8'd0;
          w_state_next      = ST_ABORT;
        end else begin
          w_conv_start_next = 1'b1;
        end
      end

      ST_ABORT: begin
        // Converter reset is held for two cycles; the pixel is dropped.
        w_conv_rst_n_next = 1'b0;
        w_cnt_next        = r_cnt + 8'd1;
        if (r_cnt == 8'd1) begin
          w_conv_rst_n_next = 1'b1;
          w_state_next      = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; converter held in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_last       <= 1'b1;
      r_cur_id     <= 1'b0;
      r_ready      <= 2'b00;
      r_conv_start <= 1'b0;
      r_conv_din   <= 24'd0;
      r_conv_rst_n <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= 24'd0;
      r_m_id       <= 1'b0;
      r_err        <= 1'b0;
      r_err_id     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_last       <= w_last_next;
      r_cur_id     <= w_cur_id_next;
      r_ready      <= w_ready_next;
      r_conv_start <= w_conv_start_next;
      r_conv_din   <= w_conv_din_next;
      r_conv_rst_n <= w_conv_rst_n_next;
      r_m_valid    <= w_m_valid_next;
      r_m_data     <= w_m_data_next;
      r_m_id       <= w_m_id_next;
      r_err        <= w_err_next;
      r_err_id     <= w_err_id_next;
    end
  end

  assign s0_ready   = r_ready[0];
  assign s1_ready   = r_ready[1];
  assign conv_start = r_conv_start;
  assign conv_din   = r_conv_din;
  assign conv_rst_n = r_conv_rst_n;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_id       = r_m_id;
  assign err        = r_err;
  assign err_id     = r_err_id;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ycbcr_conv_arbiter.sv
// Bench for ycbcr_conv_arbiter: a converter model, a transaction-level
// timeline model of the expected outputs, one per-cycle compare process and
// directed plus random stimulus.
module tb_ycbcr_conv_arbiter;
  localparam int TO   = 15;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic [23:0] s0_data = '0, s1_data = '0;
  logic        s0_ready, s1_ready, m_valid, m_id, err, err_id, busy;
  logic        conv_start, conv_rst_n;
  logic [23:0] m_data, conv_din;
  logic        conv_end = 1'b0;
  logic [23:0] conv_dout = '0;
  logic [1:0]  cv_cnt = '0;
  bit          hang = 1'b0;

  ycbcr_conv_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_id(m_id),
    .err(err), .err_id(err_id), .busy(busy),
    .conv_start(conv_start), .conv_din(conv_din), .conv_rst_n(conv_rst_n),
    .conv_end(conv_end), .conv_dout(conv_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] clip(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  // Integer BT.601 full-range RGB -> YCbCr
  function automatic logic [23:0] ycc(input logic [23:0] p);
    int r, g, b, y, cb, crr;
    r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
    y   = (77 * r + 150 * g + 29 * b) >>> 8;
    cb  = ((128 * b - 43 * r - 85 * g) >>> 8) + 128;
    crr = ((128 * r - 107 * g - 21 * b) >>> 8) + 128;
    return {clip(y), clip(cb), clip(crr)};
  endfunction

  // Converter: three steps after start, then all_end held until start drops
  always @(posedge clk) begin
    if (conv_rst_n !== 1'b1 || conv_start !== 1'b1) begin
      cv_cnt   <= 2'd0;
      conv_end <= 1'b0;
    end else if (cv_cnt != 2'd3) begin
      cv_cnt <= cv_cnt + 2'd1;
      if (cv_cnt == 2'd2) begin
        conv_end  <= !hang;
        conv_dout <= ycc(conv_din);
      end
    end
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, edge_n, act, exp);
  endtask

  // Expected output timeline, indexed by the number of the edge just taken
  typedef struct {
    bit set, rs, r0, r1, mv, er, bz, st, rn, mid, eid;
    logic [23:0] md, din;
  } row_t;
  row_t exp_q [MAXC];
  row_t xr;

  typedef struct { int e; logic [23:0] d; logic id; } obs_t;
  obs_t g_q[$], r_q[$], e_q[$];
  int   n_rn_low = 0;

  bit          m_last = 1'b1;
  int          m_free = 0;
  logic [23:0] m_din = '0;

  task automatic put(input int c, input bit r0, input bit r1, input bit mv, input bit er,
                     input bit bz, input bit st, input bit rn, input logic [23:0] md,
                     input logic [23:0] din, input bit mid, input bit eid);
    if (c < MAXC) begin
      exp_q[c].set = 1'b1; exp_q[c].rs = 1'b0;
      exp_q[c].r0 = r0; exp_q[c].r1 = r1; exp_q[c].mv = mv; exp_q[c].er = er;
      exp_q[c].bz = bz; exp_q[c].st = st; exp_q[c].rn = rn;
      exp_q[c].md = md; exp_q[c].din = din; exp_q[c].mid = mid; exp_q[c].eid = eid;
    end
  endtask

  // Transaction model: given inputs sampled at edge k, schedule the whole
  // expected reaction of one pixel (grant, result or abort) on the timeline.
  task automatic model_step(input int k);
    bit          gid;
    logic [23:0] d;
    if (k >= MAXC) return;
    if (rst) begin
      put(k, 0, 0, 0, 0, 0, 0, 0, 24'h0, 24'h0, 0, 0);
      exp_q[k].rs = 1'b1;
      m_last = 1'b1; m_din = '0; m_free = k + 1;
    end else if (k >= m_free) begin
      if (s0_valid || s1_valid) begin
        gid = (s0_valid && s1_valid) ? !m_last : s1_valid;
        d = gid ? s1_data : s0_data;
        m_last = gid; m_din = d;
        if (!hang) begin
          for (int j = 0; j < 5; j++)
            put(k + j, j == 0 && !gid, j == 0 && gid, j == 4, 0, 1, j < 4, 1, ycc(d), d, gid, 0);
          m_free = k + 5;
        end else begin
          for (int j = 0; j < TO + 3; j++)
            put(k + j, j == 0 && !gid, j == 0 && gid, 0, j == TO, j < TO + 2, j < TO,
                !(j == TO || j == TO + 1), 24'h0, d, 0, gid);
          m_free = k + TO + 3;
        end
      end else begin
        put(k, 0, 0, 0, 0, 0, 0, 1, 24'h0, m_din, 0, 0);
      end
    end
  endtask

  // Compare DUT outputs against the timeline each cycle, and log events
  always @(negedge clk) begin
    if (edge_n > 0 && edge_n < MAXC && exp_q[edge_n].set) begin
      xr = exp_q[edge_n];
      chk("s0_ready", 32'(s0_ready), 32'(xr.r0));
      chk("s1_ready", 32'(s1_ready), 32'(xr.r1));
      chk("m_valid", 32'(m_valid), 32'(xr.mv));
      chk("err", 32'(err), 32'(xr.er));
      chk("busy", 32'(busy), 32'(xr.bz));
      chk("conv_start", 32'(conv_start), 32'(xr.st));
      chk("conv_rst_n", 32'(conv_rst_n), 32'(xr.rn));
      chk("conv_din", 32'(conv_din), 32'(xr.din));
      if (xr.mv) begin
        chk("m_data", 32'(m_data), 32'(xr.md));
        chk("m_id", 32'(m_id), 32'(xr.mid));
      end
      if (xr.er) chk("err_id", 32'(err_id), 32'(xr.eid));
      if (xr.rs) begin
        chk("rst_m_data", 32'(m_data), 32'(xr.md));
        chk("rst_m_id", 32'(m_id), 32'(xr.mid));
        chk("rst_err_id", 32'(err_id), 32'(xr.eid));
      end
    end
    if (s0_ready === 1'b1) g_q.push_back('{e: edge_n, d: 24'h0, id: 1'b0});
    if (s1_ready === 1'b1) g_q.push_back('{e: edge_n, d: 24'h0, id: 1'b1});
    if (m_valid === 1'b1) r_q.push_back('{e: edge_n, d: m_data, id: m_id});
    if (err === 1'b1) e_q.push_back('{e: edge_n, d: 24'h0, id: err_id});
    if (conv_rst_n === 1'b0) n_rn_low++;
  end

  int          left [2] = '{0, 0};
  logic [23:0] pat [2] = '{24'h0, 24'h0};
  bit          rnd_data = 1'b0;

  task automatic drive();
    s0_valid = left[0] > 0;
    s1_valid = left[1] > 0;
    if (!rnd_data) begin s0_data = pat[0]; s1_data = pat[1]; end
  endtask

  // Commit current inputs to the model, advance one edge, let sources react
  task automatic tick();
    model_step(edge_n + 1);
    @(posedge clk);
    #2;
    if (s0_ready === 1'b1 && left[0] > 0) begin left[0]--; if (rnd_data) s0_data = 24'($urandom); end
    if (s1_ready === 1'b1 && left[1] > 0) begin left[1]--; if (rnd_data) s1_data = 24'($urandom); end
    drive();
  endtask

  task automatic clear_obs();
    g_q.delete(); r_q.delete(); e_q.delete(); n_rn_low = 0;
  endtask

  logic [23:0] rr_exp [2] = '{24'h4C55FF, 24'h008080};
  logic [23:0] lit_in [3] = '{24'hFFFFFF, 24'hFF0000, 24'h000000};
  logic [23:0] lit_out[3] = '{24'hFF8080, 24'h4C55FF, 24'h008080};

  initial begin
    // Hand-computed values pinning the converter model
    for (int i = 0; i < 3; i++) chk("model_ycc", 32'(ycc(lit_in[i])), 32'(lit_out[i]));

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_hold_conv_rst_n", 32'(conv_rst_n), 32'd0);
    chk("rst_hold_busy", 32'(busy), 32'd0);

    // Tie right after reset, then sustained contention: 0,1,0,1 at 5 cycles
    rst = 1'b0;
    clear_obs();
    pat[0] = 24'hFF0000; pat[1] = 24'h000000;
    left[0] = 2; left[1] = 2;
    drive();
    repeat (25) tick();
    chk("rr_grants", 32'(g_q.size()), 32'd4);
    for (int i = 0; i < g_q.size() && i < 4; i++) chk("rr_order", 32'(g_q[i].id), 32'(i % 2));
    for (int i = 1; i < g_q.size(); i++) chk("rr_gap", 32'(g_q[i].e - g_q[i-1].e), 32'd5);
    chk("rr_results", 32'(r_q.size()), 32'd4);
    for (int i = 0; i < r_q.size() && i < 4; i++) chk("rr_data", 32'(r_q[i].d), 32'(rr_exp[i % 2]));

    // Single request
    clear_obs();
    pat[0] = 24'hFFFFFF; left[0] = 1;
    drive();
    repeat (10) tick();
    chk("single_results", 32'(r_q.size()), 32'd1);
    if (r_q.size() > 0 && g_q.size() > 0) begin
      chk("single_data", 32'(r_q[0].d), 32'hFF8080);
      chk("single_id", 32'(r_q[0].id), 32'd0);
      chk("single_latency", 32'(r_q[0].e - g_q[0].e), 32'd4);
    end

    // Back-to-back from source 1
    clear_obs();
    rnd_data = 1'b1; s1_data = 24'($urandom); left[1] = 4;
    drive();
    repeat (25) tick();
    rnd_data = 1'b0;
    chk("b2b_results", 32'(r_q.size()), 32'd4);
    for (int i = 1; i < r_q.size(); i++) chk("b2b_gap", 32'(r_q[i].e - r_q[i-1].e), 32'd5);
    for (int i = 0; i < r_q.size(); i++) chk("b2b_id", 32'(r_q[i].id), 32'd1);

    // Timeout on a source 1 request, then a clean source 0 conversion
    clear_obs();
    hang = 1'b1; pat[1] = 24'h123456; left[1] = 1;
    drive();
    repeat (22) tick();
    hang = 1'b0;
    chk("to_err_count", 32'(e_q.size()), 32'd1);
    if (e_q.size() > 0 && g_q.size() > 0) begin
      chk("to_err_id", 32'(e_q[0].id), 32'd1);
      chk("to_err_delay", 32'(e_q[0].e - g_q[0].e), 32'd15);
    end
    chk("to_no_result", 32'(r_q.size()), 32'd0);
    chk("to_rstn_low_cycles", 32'(n_rn_low), 32'd2);
    clear_obs();
    pat[0] = 24'hFFFFFF; left[0] = 1;
    drive();
    repeat (10) tick();
    chk("to_after_results", 32'(r_q.size()), 32'd1);
    if (r_q.size() > 0) begin
      chk("to_after_data", 32'(r_q[0].d), 32'hFF8080);
      chk("to_after_id", 32'(r_q[0].id), 32'd0);
    end

    // Reset during the 2nd ISSUE cycle, then tie with source 1 withdrawing
    clear_obs();
    pat[0] = 24'hFFFFFF; left[0] = 1;
    drive();
    for (int i = 0; i < 10 && left[0] > 0; i++) tick();
    chk("mid_grant_seen", 32'(left[0]), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_conv_rst_n", 32'(conv_rst_n), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    pat[0] = 24'hFF0000; pat[1] = 24'h000000;
    left[0] = 1; left[1] = 1;
    drive();
    tick();
    left[1] = 0;
    drive();
    repeat (12) tick();
    chk("tie_grants", 32'(g_q.size()), 32'd2);
    if (g_q.size() > 1) chk("tie_first_id", 32'(g_q[1].id), 32'd0);
    chk("mid_results", 32'(r_q.size()), 32'd1);
    if (r_q.size() > 0) begin
      chk("tie_data", 32'(r_q[0].d), 32'h4C55FF);
      chk("tie_id", 32'(r_q[0].id), 32'd0);
    end

    // Random traffic with occasional hangs and resets
    rnd_data = 1'b1;
    for (int it = 0; it < 700; it++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (edge_n + 1 >= m_free) hang = ($urandom_range(0, 7) == 0);
      for (int n = 0; n < 2; n++) begin
        if (left[n] == 0 && $urandom_range(0, 2) == 0) left[n] = $urandom_range(1, 3);
        else if (left[n] > 0 && $urandom_range(0, 19) == 0) left[n] = 0;
      end
      drive();
      tick();
    end
    rst = 1'b0;
    while (edge_n + 1 < m_free) tick();
    hang = 1'b0;
    left[0] = 0; left[1] = 0;
    drive();
    repeat (25) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ycbcr_conv_arbiter.md
# ycbcr_conv_arbiter

Round-robin arbiter and sequencer that shares one RGB888→YCbCr colour-space converter between two pixel sources. It accepts pixels on two valid/ready ports and drives the converter's `start`/`all_end` handshake. It returns each converted pixel, tagged with its source id, and recovers the converter from a hung conversion by timeout and reset. It sits between the two capture paths and the shared converter instance.

## Interface
- `TIMEOUT`, default 15: number of cycles in ISSUE without `conv_end` before the conversion is aborted. Range 4..255.
- `clk`  in  1: single clock domain; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `s0_valid`  in  1: source 0 has a pixel.
- `s0_data`  in  24: source 0 pixel, {R,G,B}.
- `s0_ready`  out  1: one-cycle pulse when the source 0 pixel is accepted.
- `s1_valid`, `s1_data`, `s1_ready`: same as source 0, for source 1.
- `m_valid`  out  1: one-cycle pulse; converted pixel is present.
- `m_data`  out  24: {Y,Cb,Cr}.
- `m_id`  out  1: source of `m_data`.
- `err`  out  1: one-cycle pulse; a conversion was aborted.
- `err_id`  out  1: source of the aborted pixel.
- `busy`  out  1: high in any state other than IDLE.
- `conv_start`  out  1: to converter `start`.
- `conv_din`  out  24: to converter `d_in`.
- `conv_rst_n`  out  1: to converter `rst_n`, active-low.
- `conv_end`  in  1: from converter `all_end`.
- `conv_dout`  in  24: from converter `d_out`.

## Operation
- States: IDLE, ISSUE, RELEASE, ABORT.
- **Arbitration** (IDLE and RELEASE only):
  - If exactly one `sN_valid` is high, that source is granted.
  - If both are high, the source not served last is granted.
  - `last` is the id of the last granted source. It is updated on every grant, including grants that later abort.
  - Reset value of `last` is 1, so source 0 wins the first tie.
- **Grant edge**:
  - `sN_ready` pulses.
  - `conv_din` ← `sN_data`; `conv_din` is held constant until the next grant.
  - `cur_id` ← N.
  - `conv_start` ← 1.
  - State → ISSUE; timeout counter ← 0.
- **ISSUE**:
  - `conv_start` is held at 1 and the counter increments each cycle.
  - On `conv_end`=1: `m_data` ← `conv_dout`, `m_id` ← `cur_id`, `m_valid` ← 1, `conv_start` ← 0, state → RELEASE.
  - Else, if counter = TIMEOUT−1: `conv_start` ← 0, `conv_rst_n` ← 0, `err` ← 1, `err_id` ← `cur_id`, state → ABORT.
- **RELEASE**:
  - Lasts exactly one cycle with `conv_start`=0, which returns the converter to its idle state.
  - `m_valid` returns to 0.
  - Arbitration is evaluated in this state. On a grant, the next conversion starts (state → ISSUE). Otherwise state → IDLE.
- **ABORT**:
  - Holds `conv_rst_n`=0 for 2 cycles, then sets it to 1 and goes to IDLE.
  - The aborted pixel is dropped; no `m_valid` is produced for it.
- There is no backpressure on `m`; the consumer must capture on the `m_valid` pulse.
- `sN_valid` may drop without an accept; no request state is latched.

## Timing
- **Reset**: while `rst`=1, the following registers load their reset values every cycle:
  - state=IDLE
  - `conv_start`=0, `conv_din`=0
  - `conv_rst_n`=0 (the converter is held in reset)
  - `m_valid`=0, `m_data`=0, `m_id`=0
  - `err`=0, `err_id`=0
  - `sN_ready`=0, `busy`=0
  - `last`=1
  
  `conv_rst_n` goes to 1 on the first edge with `rst`=0.
- **Reset mid-conversion**: the same reset applies, so both blocks restart clean and the in-flight pixel is dropped with no `m_valid` and no `err`.
- **Per-pixel sequence** (grant at edge E0):
  - After E0: `conv_start`=1.
  - E1, E2, E3: converter steps through its pipeline; `conv_end`=1 after E3.
  - E4: controller captures `conv_dout`; `m_valid`=1 after E4.
  - E5: RELEASE completes, and the next grant may occur on this same edge.
- Latency from grant edge to `m_valid` high: 4 cycles.
- Sustained throughput: one pixel per 5 cycles, with any mix of sources.
- `sN_ready` is high for the single cycle after its grant edge. At most one ready is high per cycle.
- `conv_end` seen in any state other than ISSUE is ignored.
- `err` and `m_valid` are never high in the same cycle.

## Test plan
- **Single request.** `s0_valid`=1 with `s0_data`=0xFFFFFF for one request.
  - Expect `s0_ready` pulse, then `m_valid` 4 cycles after the grant edge, with `m_data`=0xFF8080 and `m_id`=0.
- **Contention, round-robin.** Both sources valid continuously: `s0_data`=0xFF0000, `s1_data`=0x000000.
  - Expect grants in the order 0,1,0,1 at a 5-cycle spacing.
  - Expect `m_data` to alternate 0x4C55FF (id 0) and 0x008080 (id 1).
- **Back-to-back, single source.** `s1` held valid for 4 pixels.
  - Expect exactly 4 results, consecutive `m_valid` pulses 5 cycles apart, and no idle gap between pixels.
- **Timeout.** Force `conv_end`=0 with TIMEOUT=15 and a request from source 1.
  - Expect `err` pulse with `err_id`=1 after 15 ISSUE cycles.
  - Expect `conv_rst_n` low for 2 cycles, no `m_valid`, and then a fresh request from source 0 converting correctly.
- **Reset mid-conversion.** Assert `rst` during the 2nd ISSUE cycle.
  - Expect all outputs at reset values, `conv_rst_n` low while `rst`=1, no `m_valid`.
  - After release, a source 0 request gives the correct result.
- **Tie after reset.** Both sources valid on the first cycle after reset.
  - Expect source 0 granted first.
  - Dropping `s1_valid` before its grant produces no source 1 accept.
